// File: rtl/bomb_placer.sv
// bomb_placer: turns each player's drop button into one validated placement request per bombTick.
// Optional debounce filter on the synchronized buttons is enabled with `define BOMB_PLACER_DEBOUNCE_EN.
module bomb_placer #(
  parameter int MAX_BOMBS       = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bombTick,
  input  logic [1:0]  game_state,
  input  logic        btnA,
  input  logic        btnB,
  input  logic [3:0]  playerAx,
  input  logic [3:0]  playerAy,
  input  logic [3:0]  playerBx,
  input  logic [3:0]  playerBy,
  input  logic [99:0] i_curBombMap_0,
  input  logic [99:0] i_curBombMap_1,
  output logic [3:0]  bombA_x,
  output logic [3:0]  bombA_y,
  output logic [3:0]  bombB_x,
  output logic [3:0]  bombB_y,
  output logic        bombA_v,
  output logic        bombB_v,
  output logic [1:0]  o_activeA,
  output logic [1:0]  o_activeB,
  output logic        o_rejectA,
  output logic        o_rejectB,
  output logic [1:0]  o_dbg_state
);

  // Handshake: a request is offered while bombX_v is high; the downstream map updater
  // consumes it only on a cycle where bombTick is high. No other cycle has any effect.

  if (MAX_BOMBS < 1 || MAX_BOMBS > 3 || DEBOUNCE_CYCLES < 1) begin : g_cfg_err
    $error("bomb_placer: MAX_BOMBS must be 1..3 and DEBOUNCE_CYCLES >= 1");
  end

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  // Index 0 is player A, index 1 is player B throughout.
  logic [1:0] w_btn;
  logic [1:0] r_sync1, r_sync2, r_prev;
  logic [1:0] w_level, w_press;
  logic [3:0] w_px [2];
  logic [3:0] w_py [2];

  assign w_btn   = {btnB, btnA};
  assign w_px[0] = playerAx;
  assign w_py[0] = playerAy;
  assign w_px[1] = playerBx;
  assign w_py[1] = playerBy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      r_prev  <= w_level;
    end
  end

`ifdef BOMB_PLACER_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] r_dcnt [2];
  logic [1:0]    r_filt;

  // The counter saturates at DEBOUNCE_CYCLES-1 and the filtered level stays high until a low sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_filt <= '0;
      for (int p = 0; p < 2; p++) r_dcnt[p] <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (!r_sync2[p]) begin
          r_dcnt[p] <= '0;
          r_filt[p] <= 1'b0;
        end else if (r_dcnt[p] == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_filt[p] <= 1'b1;
        end else begin
          r_dcnt[p] <= r_dcnt[p] + 1'b1;
        end
      end
    end
  end

  assign w_level = r_filt;
`else
  assign w_level = r_sync2;
`endif

  assign w_press = w_level & ~r_prev;

  state_t     r_st [2];
  state_t     w_st_nxt [2];
  logic [3:0] r_x [2];
  logic [3:0] r_y [2];
  logic [1:0] r_slot [2][MAX_BOMBS];
  logic [1:0] w_slot_nxt [2][MAX_BOMBS];
  logic [1:0] w_cnt [2];
  logic [6:0] w_idx [2];
  logic [1:0] w_occ, w_ok, w_load, w_v, w_commit, w_rej;
  logic [1:0] r_active [2];
  logic [1:0] r_rej;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_cnt[p] = '0;
      for (int s = 0; s < MAX_BOMBS; s++) w_cnt[p] = w_cnt[p] + 2'(r_slot[p][s] != 2'd0);
      w_ok[p]  = (game_state == 2'd0) &&
                 (w_px[p] >= 4'd1) && (w_px[p] <= 4'd8) &&
                 (w_py[p] >= 4'd1) && (w_py[p] <= 4'd8) &&
                 (int'(w_cnt[p]) < MAX_BOMBS);
      w_idx[p] = 7'(r_x[p]) * 7'd10 + 7'(r_y[p]);
      w_occ[p] = i_curBombMap_0[w_idx[p]] | i_curBombMap_1[w_idx[p]];
    end
  end

  // Player A wins a same-cell collision, so B's valid is masked by A's.
  always_comb begin
    w_v[0] = (r_st[0] == PEND) && !w_occ[0];
    w_v[1] = (r_st[1] == PEND) && !w_occ[1] &&
             !(w_v[0] && (r_x[0] == r_x[1]) && (r_y[0] == r_y[1]));
    for (int p = 0; p < 2; p++) begin
      w_commit[p] = (r_st[p] == PEND) && bombTick && w_v[p];
      w_rej[p]    = (r_st[p] == PEND) && bombTick && !w_v[p];
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_st_nxt[p] = r_st[p];
      w_load[p]   = 1'b0;
      case (r_st[p])
        IDLE: if (w_press[p] && w_ok[p]) begin
          w_st_nxt[p] = PEND;
          w_load[p]   = 1'b1;
        end
        PEND: if (bombTick) w_st_nxt[p] = IDLE;
        default: w_st_nxt[p] = IDLE;
      endcase
    end
  end

  // A slot loaded on this tick starts at 3 and is not decremented until the next tick.
  always_comb begin
    for (int p = 0; p < 2; p++) begin : g_slot_nxt
      logic found;
      found = 1'b0;
      for (int s = 0; s < MAX_BOMBS; s++) begin
        w_slot_nxt[p][s] = r_slot[p][s];
        if (bombTick) begin
          if (w_commit[p] && !found && (r_slot[p][s] == 2'd0)) begin
            w_slot_nxt[p][s] = 2'd3;
            found            = 1'b1;
          end else if (r_slot[p][s] != 2'd0) begin
            w_slot_nxt[p][s] = r_slot[p][s] - 2'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rej <= '0;
      for (int p = 0; p < 2; p++) begin
        r_st[p]     <= IDLE;
        r_x[p]      <= '0;
        r_y[p]      <= '0;
        r_active[p] <= '0;
        for (int s = 0; s < MAX_BOMBS; s++) r_slot[p][s] <= '0;
      end
    end else begin
      r_rej <= w_rej;
      for (int p = 0; p < 2; p++) begin
        r_st[p]     <= w_st_nxt[p];
        r_active[p] <= w_cnt[p];
        if (w_load[p]) begin
          r_x[p] <= w_px[p];
          r_y[p] <= w_py[p];
        end
        for (int s = 0; s < MAX_BOMBS; s++) r_slot[p][s] <= w_slot_nxt[p][s];
      end
    end
  end

  assign bombA_x     = r_x[0];
  assign bombA_y     = r_y[0];
  assign bombB_x     = r_x[1];
  assign bombB_y     = r_y[1];
  assign bombA_v     = w_v[0];
  assign bombB_v     = w_v[1];
  assign o_activeA   = r_active[0];
  assign o_activeB   = r_active[1];
  assign o_rejectA   = r_rej[0];
  assign o_rejectB   = r_rej[1];
  assign o_dbg_state = {r_st[1], r_st[0]};

endmodule
